// File: rtl/state_trace_monitor.sv
// state_trace_monitor: logs each change of an observed 2-bit state as {illegal, from, to, dwell} into a FIFO drained over valid/ready.
// One-edge push latency; full FIFO drops new records (sticky overflow); STATE_MON_TIMEOUT_EN adds the sticky stuck flag.

module stm_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           wdata,
  output logic [W-1:0]           head,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  // Pointers carry one extra wrap bit so wr-rd spans 0..DEPTH.
  assign level = wr_ptr - rd_ptr;
  assign full  = (level == (AW+1)'(DEPTH));
  assign empty = (wr_ptr == rd_ptr);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wdata;
  end
endmodule

module state_trace_monitor #(
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 200
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   clr,
  input  logic [1:0]             state_i,
  output logic                   rec_valid,
  input  logic                   rec_ready,
  output logic [4+CNT_W:0]       rec_data,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   overflow,
  output logic                   illegal_seen,
  output logic                   stuck
);
  localparam int RW = 5 + CNT_W;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1 || TIMEOUT >= (1 << CNT_W)) begin : g_cfg_check
    $error("state_trace_monitor: DEPTH must be a power of 2 >= 2 and TIMEOUT must fit in CNT_W");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, PRIME = 2'd1, TRACK = 2'd2} fsm_t;

  fsm_t             fsm;
  logic [1:0]       prev_state;
  logic [CNT_W-1:0] dwell_cnt;
  logic [CNT_W-1:0] dwell_inc;
  logic             tracking;
  logic             change;
  logic             legal;
  logic             pop;
  logic             full;
  logic             empty;
  logic             drop;
  logic             wr;
  logic [RW-1:0]    head;
  logic             stuck_set;

  assign dwell_inc = (dwell_cnt == {CNT_W{1'b1}}) ? dwell_cnt : dwell_cnt + 1'b1;
  assign tracking  = (fsm == TRACK) && en;
  assign change    = tracking && (state_i != prev_state);

  // Legal walk is ts0->ts1->ts2->ts0; any state may also fall back to ts0.
  always_comb begin
    legal = 1'b0;
    case ({prev_state, state_i})
      4'b00_01, 4'b01_10, 4'b10_00, 4'b01_00, 4'b11_00: legal = 1'b1;
      default:                                          legal = 1'b0;
    endcase
  end

  assign pop  = rec_valid && rec_ready;
  assign drop = change && full && !pop;
  assign wr   = change && !drop;

  stm_fifo #(.DEPTH(DEPTH), .W(RW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr),
    .pop   (pop),
    .wdata ({~legal, prev_state, state_i, dwell_cnt}),
    .head  (head),
    .level (fifo_level),
    .full  (full),
    .empty (empty)
  );

  assign rec_valid = ~empty;
  assign rec_data  = rec_valid ? head : '0;

`ifdef STATE_MON_TIMEOUT_EN
  localparam logic [CNT_W-1:0] STUCK_AT = CNT_W'(TIMEOUT);
  // ts0 is the idle state and is exempt from the dwell timeout.
  assign stuck_set = tracking && !change && (prev_state != 2'd0) && (dwell_inc >= STUCK_AT);
`else
  assign stuck_set = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm          <= IDLE;
      prev_state   <= 2'd0;
      dwell_cnt    <= '0;
      overflow     <= 1'b0;
      illegal_seen <= 1'b0;
      stuck        <= 1'b0;
    end else begin
      // A flag-setting event beats a same-cycle clear.
      overflow     <= drop | (overflow & ~clr);
      illegal_seen <= (change & ~legal) | (illegal_seen & ~clr);
      stuck        <= stuck_set | (stuck & ~clr);

      if (!en) begin
        fsm       <= IDLE;
        dwell_cnt <= '0;
      end else begin
        case (fsm)
          IDLE: fsm <= PRIME;
          PRIME: begin
            prev_state <= state_i;
            dwell_cnt  <= CNT_W'(1);
            fsm        <= TRACK;
          end
          TRACK: begin
            if (state_i != prev_state) begin
              prev_state <= state_i;
              dwell_cnt  <= CNT_W'(1);
            end else begin
              dwell_cnt <= dwell_inc;
            end
          end
          default: fsm <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_state_trace_monitor.sv
// Bench for state_trace_monitor: directed test-plan steps then random traffic, checked against a run-length/queue reference model.
module tb_state_trace_monitor;
  localparam int DEPTH   = 4;
  localparam int CNT_W   = 8;
  localparam int TIMEOUT = 200;
  localparam int RW      = 5 + CNT_W;
  localparam int LW      = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic          clr = 1'b0;
  logic          rec_ready = 1'b0;
  logic [1:0]    state_i = 2'd0;
  logic          rec_valid;
  logic [RW-1:0] rec_data;
  logic [LW-1:0] fifo_level;
  logic          overflow;
  logic          illegal_seen;
  logic          stuck;

  int checks = 0;
  int errors = 0;

  state_trace_monitor #(.DEPTH(DEPTH), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .clr          (clr),
    .state_i      (state_i),
    .rec_valid    (rec_valid),
    .rec_ready    (rec_ready),
    .rec_data     (rec_data),
    .fifo_level   (fifo_level),
    .overflow     (overflow),
    .illegal_seen (illegal_seen),
    .stuck        (stuck)
  );

  always #5 clk = ~clk;

  // Reference model: records in flight, current run value/length, enabled-edge count.
  logic [RW-1:0] q[$];
  int            en_run;
  int            run_len;
  int            cur;
  bit            m_ovf;
  bit            m_ill;
  bit            m_stuck;

  function automatic logic [RW-1:0] pack(input int ill, input int f, input int t, input int d);
    int dd;
    logic [RW-1:0] r;
    dd = (d > (1 << CNT_W) - 1) ? (1 << CNT_W) - 1 : d;
    r = {ill[0], f[1:0], t[1:0], dd[CNT_W-1:0]};
    return r;
  endfunction

  function automatic bit legal_step(input int f, input int t);
    return (t == 0) || ((t == f + 1) && (t <= 2));
  endfunction

  task automatic model_reset();
    q.delete();
    en_run = 0;
    run_len = 0;
    cur = 0;
    m_ovf = 0;
    m_ill = 0;
    m_stuck = 0;
  endtask

  task automatic model_edge(input bit e, input bit c, input int s, input bit r);
    bit pop_now, set_ill, set_ovf, set_stuck, push_now;
    logic [RW-1:0] rec_new;
    pop_now = (q.size() != 0) && r;
    set_ill = 0;
    set_ovf = 0;
    set_stuck = 0;
    push_now = 0;
    rec_new = '0;
    if (!e) begin
      en_run = 0;
      run_len = 0;
    end else begin
      if (en_run == 1) begin
        cur = s;
        run_len = 1;
      end else if (en_run >= 2) begin
        if (s == cur) begin
          run_len++;
          if (cur != 0 && run_len >= TIMEOUT) set_stuck = 1;
        end else begin
          set_ill = !legal_step(cur, s);
          if (q.size() == DEPTH && !pop_now) set_ovf = 1;
          else begin
            push_now = 1;
            rec_new = pack(set_ill ? 1 : 0, cur, s, run_len);
          end
          cur = s;
          run_len = 1;
        end
      end
      if (en_run < 2) en_run++;
    end
`ifndef STATE_MON_TIMEOUT_EN
    set_stuck = 0;
`endif
    if (pop_now) void'(q.pop_front());
    if (push_now) q.push_back(rec_new);
    m_ovf = set_ovf | (m_ovf & !c);
    m_ill = set_ill | (m_ill & !c);
    m_stuck = set_stuck | (m_stuck & !c);
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("rec_valid", 32'(rec_valid), 32'(q.size() != 0));
    chk("fifo_level", 32'(fifo_level), q.size());
    chk("rec_data", 32'(rec_data), (q.size() != 0) ? 32'(q[0]) : 32'd0);
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("illegal_seen", 32'(illegal_seen), 32'(m_ill));
    chk("stuck", 32'(stuck), 32'(m_stuck));
  endtask

  task automatic tick(input bit e, input bit c, input int s, input bit r);
    en = e;
    clr = c;
    state_i = s[1:0];
    rec_ready = r;
    model_edge(e, c, s, r);
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    chk("reset_data", 32'(rec_data), 32'd0);
    rst = 1'b1;

    // Prime: state 0 sampled for 5 cycles, then 1.
    repeat (6) tick(1, 0, 0, 0);
    chk("prime_no_rec", 32'(rec_valid), 32'd0);
    tick(1, 0, 1, 0);
    chk("prime_rec", 32'(rec_data), 32'(pack(0, 0, 1, 5)));
    tick(1, 0, 2, 0);
    tick(1, 0, 0, 0);
    chk("queued3", 32'(fifo_level), 32'd3);

    // Asynchronous reset mid-cycle with records queued.
    #3 rst = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("arst_level", 32'(fifo_level), 32'd0);
    chk("arst_valid", 32'(rec_valid), 32'd0);
    @(posedge clk);
    #1;
    check_all();
    rst = 1'b1;

    // Legal cycle 0(3) -> 1(2) -> 2(4) -> 0 with the sink ready.
    tick(1, 0, 1, 1);
    tick(1, 0, 1, 1);
    repeat (3) tick(1, 0, 0, 1);
    tick(1, 0, 1, 1);
    chk("legal_01", 32'(rec_data), 32'(pack(0, 0, 1, 3)));
    tick(1, 0, 1, 1);
    tick(1, 0, 2, 1);
    chk("legal_12", 32'(rec_data), 32'(pack(0, 1, 2, 2)));
    repeat (3) tick(1, 0, 2, 1);
    tick(1, 0, 0, 1);
    chk("legal_20", 32'(rec_data), 32'(pack(0, 2, 0, 4)));
    chk("legal_no_ill", 32'(illegal_seen), 32'd0);
    tick(1, 0, 0, 1);

    // Illegal 0->2 and 2->3, clear, then clear colliding with a new illegal event.
    tick(1, 0, 2, 0);
    chk("ill_02_bit", 32'(rec_data[RW-1]), 32'd1);
    chk("ill_seen", 32'(illegal_seen), 32'd1);
    tick(1, 0, 3, 0);
    repeat (3) tick(1, 0, 3, 1);
    tick(1, 1, 3, 1);
    chk("ill_clr", 32'(illegal_seen), 32'd0);
    tick(1, 1, 1, 1);
    chk("ill_set_beats_clr", 32'(illegal_seen), 32'd1);
    tick(1, 1, 1, 1);

    // Backpressure: five changes into a four-deep FIFO.
    tick(1, 0, 2, 0);
    tick(1, 0, 0, 0);
    tick(1, 0, 1, 0);
    tick(1, 0, 2, 0);
    tick(1, 0, 0, 0);
    chk("ovf_level", 32'(fifo_level), 32'd4);
    chk("ovf_flag", 32'(overflow), 32'd1);
    repeat (3) tick(1, 0, 0, 0);
    tick(1, 0, 1, 1);
    chk("full_pushpop_level", 32'(fifo_level), 32'd4);
    tick(1, 1, 1, 0);
    chk("ovf_clr", 32'(overflow), 32'd0);
    repeat (5) tick(1, 0, 1, 1);

    // Dwell saturation.
    repeat (300) tick(1, 0, 1, 1);
    tick(1, 0, 2, 0);
    chk("sat_dwell", 32'(rec_data), 32'(pack(0, 1, 2, 255)));
    tick(1, 0, 2, 1);

    // Disable across a change, then re-prime.
    tick(0, 0, 1, 1);
    chk("dis_no_rec", 32'(fifo_level), 32'd0);
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    tick(1, 0, 1, 0);
    chk("reprime_rec", 32'(rec_data), 32'(pack(0, 0, 1, 1)));
    tick(1, 0, 1, 1);

    // Dwell timeout on state 2, none on state 0.
    tick(1, 1, 2, 1);
    repeat (198) tick(1, 0, 2, 1);
    chk("stuck_before", 32'(stuck), 32'd0);
    tick(1, 0, 2, 1);
`ifdef STATE_MON_TIMEOUT_EN
    chk("stuck_at_timeout", 32'(stuck), 32'd1);
`else
    chk("stuck_tied_low", 32'(stuck), 32'd0);
`endif
    tick(1, 1, 2, 1);
    tick(1, 0, 0, 1);
    tick(1, 1, 0, 1);
    repeat (300) tick(1, 0, 0, 1);
    chk("stuck_idle_state", 32'(stuck), 32'd0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      bit e, c, r;
      int s;
      e = ($urandom_range(0, 15) != 0);
      c = ($urandom_range(0, 31) == 0);
      r = ($urandom_range(0, 2) != 0);
      s = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : int'(state_i);
      tick(e, c, s, r);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/state_trace_monitor.md
Name: state_trace_monitor

Overview:
- Downstream observer of the 2-bit enum state register (encoding ts0=0, ts1=1, ts2=2, ts3=3).
- Samples the state every cycle and detects each state change.
- Builds one transition record per change {illegal, from, to, dwell}, buffers it in a small FIFO and drains it over a valid/ready interface to a debug/trace sink.
- Flags transitions outside the legal sequence ts0→ts1→ts2→ts0, plus any→ts0.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, ≥2.
- CNT_W, 8, dwell counter width; saturates at 2^CNT_W−1.
- TIMEOUT, 200, stuck threshold in cycles; used only with STATE_MON_TIMEOUT_EN; must be < 2^CNT_W.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  monitoring enable.
- clr  in  1  synchronous clear of sticky flags.
- state_i  in  2  observed state value.
- rec_valid  out  1  record available.
- rec_ready  in  1  sink accepts record.
- rec_data  out  5+CNT_W  {illegal[1], from[2], to[2], dwell[CNT_W]}, MSB first.
- fifo_level  out  $clog2(DEPTH)+1  entries held.
- overflow  out  1  sticky: record dropped.
- illegal_seen  out  1  sticky: illegal transition seen.
- stuck  out  1  dwell timeout flag (feature only).

Behaviour:
- Reset (rst=0, asynchronous): FSM=IDLE, prev_state=0, dwell_cnt=0, FIFO empty, rec_valid=0, rec_data=0, fifo_level=0, overflow=0, illegal_seen=0, stuck=0.
- FSM states:
  - IDLE: en=1 → PRIME.
  - PRIME: one cycle; prev_state<=state_i, dwell_cnt<=1 → TRACK.
  - TRACK: en=0 → IDLE; else stays in TRACK.
- en=0 in any state: go to IDLE next edge, dwell_cnt<=0, no push; FIFO contents and drain unaffected.
- TRACK, state_i==prev_state: dwell_cnt saturating increment.
- TRACK, state_i!=prev_state:
  - Push record {illegal, prev_state, state_i, dwell_cnt}.
  - prev_state<=state_i, dwell_cnt<=1.
- Legal transitions: 0→1, 1→2, 2→0, 1→0, 3→0. Every other change sets illegal=1 in the record and sets illegal_seen next edge, including entry into 3.
- Push latency: rec_valid rises the edge after the change cycle when the FIFO was empty; no combinational path from state_i to rec_*.
- Handshake:
  - Pop occurs when rec_valid && rec_ready.
  - rec_data is the head entry and stays stable while rec_valid=1 && rec_ready=0.
  - rec_ready has no effect when empty.
- Full FIFO:
  - Push with no pop that cycle: record dropped, overflow<=1, level unchanged.
  - Push with pop the same cycle: both happen, level unchanged, no overflow.
- Empty FIFO: simultaneous push and pop is impossible (rec_valid=0), so the push is accepted.
- Pointers are DEPTH-wrap binary; fifo_level = wr−rd, range 0..DEPTH.
- clr=1 zeroes overflow, illegal_seen and stuck.
  - An event setting a flag in the same cycle as clr wins: the flag reads 1.
  - clr does not touch the FIFO.
- Dwell counts sampled cycles including the entry cycle; it saturates at 2^CNT_W−1 and never wraps.

Optional Feature:
- Macro: STATE_MON_TIMEOUT_EN.
- Defined:
  - stuck<=1 when in TRACK and dwell_cnt reaches TIMEOUT while prev_state!=0.
  - stuck is sticky until clr or reset.
  - ts0 is idle and never times out.
- Undefined: stuck tied to 0; TIMEOUT unused; no extra counter logic.

Test Plan:
- Reset/prime: rst low mid-record with 3 entries queued → all outputs 0 immediately; after release, en=1, state held 0 for 5 cycles then 1 → one record {0,0,1,5}, rec_valid one cycle after the change.
- Legal cycle: 0(3 cycles)→1(2)→2(4)→0 with rec_ready=1 → records {0,0,1,3}, {0,1,2,2}, {0,2,0,4}; illegal_seen stays 0.
- Illegal: change 0→2, then 2→3 → both records have illegal=1; illegal_seen=1; clr pulse → illegal_seen=0.
- Backpressure/overflow (DEPTH=4): rec_ready=0, 5 changes → fifo_level=4, overflow=1, fifth record lost. Then rec_ready=1 with a change in the same cycle → level stays 4, no further loss, head data stable until popped.
- Saturation/disable: hold state 1 for 300 cycles (CNT_W=8), then →2 → dwell=255. en=0 during a change → no record, FSM re-primes on re-enable.
- Feature on: hold state 2 for 200 cycles → stuck=1 at the 200th sampled cycle. Hold state 0 for 300 cycles → stuck stays 0.
